serial_add_sequencer: RTL and testbench

- Word-level front end for the registered 1-bit full adder stage.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Streams operand bits LSB-first into the adder, one bit per cycle, feeding the adder's registered carry back as the next carry-in.
- Collects the adder's registered sum bits and returns the WIDTH-bit sum plus carry-out over a second valid/ready handshake.
- Sits directly upstream of the adder (drives A/B/cin) and directly downstream of it (consumes sum/carry).

---
 rtl/serial_add_sequencer.sv | 151 +++++++++++++++
 tb/tb_serial_add_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - word-level front end for a registered 1-bit full adder
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_cin;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_release;

    assign w_accept  = in_valid && in_ready;
    assign w_release = (r_state == DONE) && r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and adder-facing outputs. The carry fed back after the
    // first bit comes straight from the adder's carry register.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        add_a       = 1'b0;
        add_b       = 1'b0;
        add_cin     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst;
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                add_a   = r_a_sr[0];
                add_b   = r_b_sr[0];
                add_cin = (r_cnt == '0) ? r_cin : add_carry;
                if (r_cnt == LAST) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifting and result assembly. Sum bits arrive one cycle after
    // their operand bits, so they are shifted in MSB-side and land in place
    // after the final capture in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sr <= in_a;
                        r_b_sr <= in_b;
                        r_cin  <= in_cin;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    if (r_cnt != LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (r_cnt != '0) begin
                        r_res <= {add_sum, r_res[WIDTH-1:1]};
                    end
                end
                DRAIN: begin
                    r_res      <= {add_sum, r_res[WIDTH-1:1]};
                    r_out_sum  <= {add_sum, r_res[WIDTH-1:1]};
                    r_out_cout <= add_carry;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed self-checking bench for serial_add_sequencer
module tb_serial_add_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       add_a;
    logic       add_b;
    logic       add_cin;
    logic       add_sum;
    logic       add_carry;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;

    int vectors;
    int miscompares;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered 1-bit full adder stage sharing the sequencer reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_sum   <= 1'b0;
            add_carry <= 1'b0;
        end else begin
            {add_carry, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {1'b0, add_cin};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge, hold until accepted, then drop valid
    // at the falling edge after the accept edge (first SHIFT cycle).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        int budget;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sample adder inputs over the eight SHIFT cycles, starting at the current
    // falling edge.
    task automatic collect(output logic [7:0] abits, output logic [7:0] cbits);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            abits[i] = add_a;
            cbits[i] = add_cin;
        end
    endtask

    // Wait (bounded) for out_valid and check the result; lat counts falling
    // edges since the accept edge.
    task automatic finish_op(input string tag, input logic [7:0] es, input logic ec,
                             input int lat0, output int lat);
        lat = lat0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'(out_sum),   64'(es));
        check({tag, "_cout"},  64'(out_cout),  64'(ec));
    endtask

    initial begin
        logic [7:0] abits;
        logic [7:0] cbits;
        logic       stable;
        int         lat;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_a        = 8'h00;
        in_b        = 8'h00;
        in_cin      = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_add_bits",  64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // 0x5A + 0x3C = 0x096, with bit order and latency checks
        start_op(8'h5A, 8'h3C, 1'b0);
        collect(abits, cbits);
        check("t1_add_a_seq", 64'(abits), 64'h5A);
        finish_op("t1", 8'h96, 1'b0, 7, lat);
        check("t1_latency", 64'(lat), 64'd10);
        @(negedge clk);
        check("t1_valid_drop", 64'(out_valid), 64'd0);
        check("t1_ready_back", 64'(in_ready), 64'd1);

        // Full carry ripple: 0xFF + 0x01 = 0x100
        start_op(8'hFF, 8'h01, 1'b0);
        finish_op("t2", 8'h00, 1'b1, 0, lat);
        @(negedge clk);

        // 0xFF + 0xFF + 1 = 0x1FF
        start_op(8'hFF, 8'hFF, 1'b1);
        finish_op("t3", 8'hFF, 1'b1, 0, lat);
        @(negedge clk);

        // 0 + 0 + 1 = 0x001; carry-in only in the first SHIFT cycle
        start_op(8'h00, 8'h00, 1'b1);
        collect(abits, cbits);
        check("t4_cin_seq", 64'(cbits), 64'h01);
        finish_op("t4", 8'h01, 1'b0, 7, lat);
        @(negedge clk);

        // Backpressure: result held while out_ready low for 5 cycles
        out_ready = 1'b0;
        start_op(8'h5A, 8'h3C, 1'b0);
        finish_op("t5", 8'h96, 1'b0, 0, lat);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_sum === 8'h96 && in_ready === 1'b0)) stable = 1'b0;
        end
        check("t5_stall_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_valid_drop", 64'(out_valid), 64'd0);
        check("t5_ready_back", 64'(in_ready), 64'd1);
        check("t5_sum_retained", 64'(out_sum), 64'h96);
        out_ready = 1'b1;

        // Back-to-back with in_valid held high: 0x0F+0x01 then 0x80+0x80+1
        in_a     = 8'h0F;
        in_b     = 8'h01;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a   = 8'h80;
        in_b   = 8'h80;
        in_cin = 1'b1;
        finish_op("t6a", 8'h10, 1'b0, 0, lat);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t6_second_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        finish_op("t6b", 8'h01, 1'b1, 0, lat);
        @(negedge clk);

        // Reset during SHIFT at cnt=4 aborts the operation
        start_op(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t7_rst_in_ready",  64'(in_ready),  64'd0);
        check("t7_rst_add_bits",  64'({add_a, add_b, add_cin}), 64'd0);
        check("t7_rst_out_valid", 64'(out_valid), 64'd0);
        check("t7_rst_out_sum",   64'(out_sum),   64'd0);
        check("t7_rst_out_cout",  64'(out_cout),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
        end
        check("t7_no_valid_idle", 64'(stable), 64'd1);
        start_op(8'h12, 8'h34, 1'b0);
        finish_op("t7", 8'h46, 1'b0, 0, lat);
        check("t7_latency", 64'(lat), 64'd10);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
